// File: rtl/spi_cfg_pkg.sv
// Shared constants, receive-FSM state type and frame helpers for the SPI
// configuration receiver.
package spi_cfg_pkg;

    localparam logic [7:0]  HDR_BYTE  = 8'hA5;
    localparam int unsigned FRAME_LEN = 8;

    localparam logic [7:0] WAVE_SIN = 8'd1;
    localparam logic [7:0] WAVE_SQU = 8'd2;
    localparam logic [7:0] WAVE_TRI = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BODY  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DRAIN = 3'd4
    } rx_state_t;

    function automatic logic wave_valid(input logic [7:0] wave);
        return (wave == WAVE_SIN) || (wave == WAVE_SQU) || (wave == WAVE_TRI);
    endfunction

endpackage

// File: rtl/spi_cfg_receiver_if.sv
// SPI pin bundle between the STM32 master and the configuration receiver.
interface spi_cfg_receiver_if;

    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_cfg_receiver_chk.sv
// Protocol checker: SCK half-period lower bound and strobe exclusivity.
module spi_cfg_receiver_chk #(
    parameter int SCK_MIN_HALF = 3
) (
    input logic clk,
    input logic rst,
    input logic sck_edge,
    input logic cs_n_sync,
    input logic cfg_stb,
    input logic frame_err
);

    logic [7:0] run_r;
    logic       seen_r;

    // Cycles since the previous synchronized SCK edge, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_r  <= 8'd0;
            seen_r <= 1'b0;
        end else if (sck_edge) begin
            run_r  <= 8'd0;
            seen_r <= 1'b1;
        end else if (run_r != 8'hFF) begin
            run_r <= run_r + 8'd1;
        end
    end

    a_sck_half: assert property (@(posedge clk) disable iff (rst)
        (sck_edge && seen_r && !cs_n_sync) |-> (run_r >= 8'(SCK_MIN_HALF - 1)));

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(cfg_stb && frame_err));

endmodule

// File: rtl/spi_cfg_receiver_pin_sync.sv
// Two-flop synchronizer for SCK/CS/MOSI followed by a registered edge detector;
// every output lags its pin by three clk edges.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [1:0] sck_ff_r;
    logic [1:0] cs_ff_r;
    logic [1:0] mosi_ff_r;
    logic       sck_d_r;
    logic       cs_d_r;

    // CS resets to "selected" so that a reset taken mid-frame never fakes a
    // CS fall; the only possible spurious edge is a rise seen while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_ff_r  <= 2'b00;
            cs_ff_r   <= 2'b00;
            mosi_ff_r <= 2'b00;
            sck_d_r   <= 1'b0;
            cs_d_r    <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            cs_n_sync <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_ff_r  <= {sck_ff_r[0], sck};
            cs_ff_r   <= {cs_ff_r[0], cs_n};
            mosi_ff_r <= {mosi_ff_r[0], mosi};
            sck_d_r   <= sck_ff_r[1];
            cs_d_r    <= cs_ff_r[1];
            sck_rise  <= sck_ff_r[1] & ~sck_d_r;
            sck_fall  <= ~sck_ff_r[1] & sck_d_r;
            cs_rise   <= cs_ff_r[1] & ~cs_d_r;
            cs_fall   <= ~cs_ff_r[1] & cs_d_r;
            cs_n_sync <= cs_ff_r[1];
            mosi_sync <= mosi_ff_r[1];
        end
    end

endmodule

// File: rtl/spi_cfg_receiver.sv
// SPI slave that receives 8-byte waveform configuration frames, validates
// header/wave/checksum and commits wave, frequency and amplitude atomically.
module spi_cfg_receiver
    import spi_cfg_pkg::*;
#(
    parameter int SCK_MIN_HALF = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_cfg_receiver_if.slave        spi,
    output logic [7:0]               pic_dat,
    output logic [23:0]              fre_dat,
    output logic [15:0]              amp_dat,
    output logic                     SPI_OK,
    output logic                     cfg_stb,
    output logic                     frame_err
);

    localparam logic [2:0] LAST_BODY_IDX = 3'(FRAME_LEN - 2);

    rx_state_t   state_r;
    rx_state_t   state_next;
    logic        sck_rise_s;
    logic        sck_fall_s;
    logic        cs_rise_s;
    logic        cs_fall_s;
    logic        cs_n_sync_s;
    logic        mosi_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  byte_cnt_r;
    logic [6:0]  sr_r;
    logic [7:0]  xor_r;
    logic [47:0] shadow_r;
    logic [7:0]  miso_sr_r;
    logic        miso_r;
    logic        last_err_r;
    logic [7:0]  byte_s;
    logic [7:0]  status_s;
    logic        byte_done_s;
    logic        rx_active_s;
    logic        commit_s;
    logic        reject_s;
    logic        capture_s;

    spi_pin_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sck       (spi.spi_sck),
        .cs_n      (spi.spi_cs_n),
        .mosi      (spi.spi_mosi),
        .sck_rise  (sck_rise_s),
        .sck_fall  (sck_fall_s),
        .cs_rise   (cs_rise_s),
        .cs_fall   (cs_fall_s),
        .cs_n_sync (cs_n_sync_s),
        .mosi_sync (mosi_s)
    );

    spi_cfg_receiver_chk #(.SCK_MIN_HALF(SCK_MIN_HALF)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .sck_edge  (sck_rise_s | sck_fall_s),
        .cs_n_sync (cs_n_sync_s),
        .cfg_stb   (cfg_stb),
        .frame_err (frame_err)
    );

    assign byte_s      = {sr_r, mosi_s};
    assign byte_done_s = (bit_cnt_r == 3'd7);
    assign rx_active_s = (state_r == ST_HDR) || (state_r == ST_BODY) || (state_r == ST_CHK);
    assign status_s    = {6'b000000, last_err_r, SPI_OK};
    assign spi.spi_miso = miso_r;

    // Receive state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state and frame verdict; CS edges take priority over SCK.
    always_comb begin
        state_next = state_r;
        commit_s   = 1'b0;
        reject_s   = 1'b0;
        capture_s  = 1'b0;
        if (cs_fall_s) begin
            state_next = ST_HDR;
        end else if (cs_rise_s) begin
            state_next = ST_IDLE;
            reject_s   = rx_active_s;
        end else if (sck_rise_s && rx_active_s && byte_done_s) begin
            case (state_r)
                ST_HDR: begin
                    if (byte_s == HDR_BYTE) begin
                        state_next = ST_BODY;
                    end else begin
                        state_next = ST_DRAIN;
                        reject_s   = 1'b1;
                    end
                end
                ST_BODY: begin
                    capture_s = 1'b1;
                    if (byte_cnt_r == LAST_BODY_IDX) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_BODY;
                    end
                end
                ST_CHK: begin
                    state_next = ST_DRAIN;
                    if ((byte_s == xor_r) && wave_valid(shadow_r[47:40])) begin
                        commit_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end
                default: begin
                    state_next = state_r;
                end
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // Bit/byte counters, shift register, shadow frame and running XOR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 3'd0;
            sr_r       <= 7'd0;
            xor_r      <= 8'd0;
            shadow_r   <= 48'd0;
        end else if (cs_fall_s || cs_rise_s) begin
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 3'd0;
            sr_r       <= 7'd0;
            xor_r      <= 8'd0;
            shadow_r   <= 48'd0;
        end else if (sck_rise_s && rx_active_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            sr_r      <= byte_s[6:0];
            if (byte_done_s) begin
                byte_cnt_r <= byte_cnt_r + 3'd1;
            end
            if (capture_s) begin
                shadow_r <= {shadow_r[39:0], byte_s};
                xor_r    <= xor_r ^ byte_s;
            end
        end
    end

    // Committed configuration, sticky status and one-cycle event strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pic_dat    <= WAVE_SIN;
            fre_dat    <= 24'd0;
            amp_dat    <= 16'd0;
            SPI_OK     <= 1'b0;
            cfg_stb    <= 1'b0;
            frame_err  <= 1'b0;
            last_err_r <= 1'b0;
        end else begin
            cfg_stb   <= commit_s;
            frame_err <= reject_s;
            if (commit_s) begin
                pic_dat    <= shadow_r[47:40];
                fre_dat    <= shadow_r[39:16];
                amp_dat    <= shadow_r[15:0];
                SPI_OK     <= 1'b1;
                last_err_r <= 1'b0;
            end else if (reject_s) begin
                last_err_r <= 1'b1;
            end
        end
    end

    // Status readback: MSB appears with CS fall, later bits on SCK falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sr_r <= 8'd0;
            miso_r    <= 1'b0;
        end else if (cs_fall_s) begin
            miso_r    <= status_s[7];
            miso_sr_r <= {status_s[6:0], 1'b0};
        end else if (cs_n_sync_s) begin
            miso_r    <= 1'b0;
            miso_sr_r <= 8'd0;
        end else if (sck_fall_s) begin
            miso_r    <= miso_sr_r[7];
            miso_sr_r <= {miso_sr_r[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_cfg_receiver.sv
// Randomized frame-level bench for spi_cfg_receiver against a frame-rule model.
module tb_spi_cfg_receiver;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pic_dat;
    logic [23:0] fre_dat;
    logic [15:0] amp_dat;
    logic        SPI_OK;
    logic        cfg_stb;
    logic        frame_err;

    spi_cfg_receiver_if spi ();

    spi_cfg_receiver #(.SCK_MIN_HALF(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .pic_dat   (pic_dat),
        .fre_dat   (fre_dat),
        .amp_dat   (amp_dat),
        .SPI_OK    (SPI_OK),
        .cfg_stb   (cfg_stb),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int stb_cyc = -1;
    int err_cyc = -1;

    logic [7:0]  fr [8];
    int          rise_cyc [64];
    int          cs_rise_cyc;
    logic [7:0]  miso_byte;

    logic [7:0]  m_pic;
    logic [23:0] m_fre;
    logic [15:0] m_amp;
    logic        m_ok;
    logic        m_lerr;

    // Event monitor sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (cfg_stb) begin
                stb_cnt = stb_cnt + 1;
                stb_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
            end
            if (cfg_stb && frame_err) both_cnt = both_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_pic  = 8'd1;
        m_fre  = 24'd0;
        m_amp  = 16'd0;
        m_ok   = 1'b0;
        m_lerr = 1'b0;
    endtask

    task automatic make_frame(input logic [7:0] wave, input logic [23:0] fre,
                              input logic [15:0] amp, input logic bad_chk);
        fr[0] = 8'hA5;
        fr[1] = wave;
        fr[2] = fre[23:16];
        fr[3] = fre[15:8];
        fr[4] = fre[7:0];
        fr[5] = amp[15:8];
        fr[6] = amp[7:0];
        fr[7] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5] ^ fr[6] ^ (bad_chk ? 8'h01 : 8'h00);
    endtask

    task automatic send_frame(input int nbytes);
        spi.spi_cs_n = 1'b0;
        tick(H);
        miso_byte = 8'h00;
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi.spi_mosi = fr[b][i];
                tick(H);
                if (b == 0) miso_byte[i] = spi.spi_miso;
                spi.spi_sck = 1'b1;
                rise_cyc[b*8 + 7 - i] = cyc;
                tick(H);
                spi.spi_sck = 1'b0;
            end
        end
        tick(H);
        spi.spi_cs_n = 1'b1;
        cs_rise_cyc = cyc;
        tick(10);
    endtask

    task automatic run_frame(input int nbytes, input string tag);
        int         s0;
        int         e0;
        int         ev;
        logic       commit;
        logic       reject;
        logic [7:0] status;
        logic [7:0] x;
        s0 = stb_cnt;
        e0 = err_cnt;
        status = {6'd0, m_lerr, m_ok};
        send_frame(nbytes);
        x = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5] ^ fr[6];
        commit = 1'b0;
        reject = 1'b0;
        ev = -1;
        if (nbytes >= 1 && fr[0] != 8'hA5) begin
            reject = 1'b1;
            ev = rise_cyc[7];
        end else if (nbytes < 8) begin
            reject = 1'b1;
            ev = cs_rise_cyc;
        end else if (fr[7] == x && fr[1] >= 8'd1 && fr[1] <= 8'd3) begin
            commit = 1'b1;
            ev = rise_cyc[63];
        end else begin
            reject = 1'b1;
            ev = rise_cyc[63];
        end
        if (commit) begin
            m_pic  = fr[1];
            m_fre  = {fr[2], fr[3], fr[4]};
            m_amp  = {fr[5], fr[6]};
            m_ok   = 1'b1;
            m_lerr = 1'b0;
        end else begin
            m_lerr = 1'b1;
        end
        check_val({tag, ":stb_count"}, 64'(stb_cnt - s0), {63'd0, commit});
        check_val({tag, ":err_count"}, 64'(err_cnt - e0), {63'd0, reject});
        if (commit) check_val({tag, ":stb_cycle"}, 64'(stb_cyc), 64'(ev + 4));
        if (reject) check_val({tag, ":err_cycle"}, 64'(err_cyc), 64'(ev + 4));
        check_val({tag, ":pic"}, {56'd0, pic_dat}, {56'd0, m_pic});
        check_val({tag, ":fre"}, {40'd0, fre_dat}, {40'd0, m_fre});
        check_val({tag, ":amp"}, {48'd0, amp_dat}, {48'd0, m_amp});
        check_val({tag, ":ok"}, {63'd0, SPI_OK}, {63'd0, m_ok});
        if (nbytes >= 1) check_val({tag, ":miso"}, {56'd0, miso_byte}, {56'd0, status});
    endtask

    initial begin
        int kind;
        int n;
        int s0;
        int e0;
        spi.spi_sck  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        model_reset();
        tick(3);
        check_val("rst:pic", {56'd0, pic_dat}, 64'd1);
        check_val("rst:fre", {40'd0, fre_dat}, 64'd0);
        check_val("rst:amp", {48'd0, amp_dat}, 64'd0);
        check_val("rst:ok", {63'd0, SPI_OK}, 64'd0);
        check_val("rst:strobes", {62'd0, cfg_stb, frame_err}, 64'd0);
        rst = 1'b0;
        tick(20);
        check_val("idle:strobes", 64'(stb_cnt + err_cnt), 64'd0);
        check_val("idle:miso", {63'd0, spi.spi_miso}, 64'd0);

        fr = '{8'hA5, 8'h01, 8'h00, 8'h27, 8'h10, 8'h00, 8'h80, 8'hB6};
        run_frame(8, "valid1");
        fr[7] = 8'hB7;
        run_frame(8, "badchk");
        make_frame(8'h04, 24'h002710, 16'h0080, 1'b0);
        run_frame(8, "badwave");
        make_frame(8'h01, 24'h002710, 16'h0080, 1'b0);
        fr[0] = 8'h5A;
        run_frame(8, "badhdr");
        make_frame(8'h02, 24'hABCDEF, 16'h1234, 1'b0);
        run_frame(4, "short");
        make_frame(8'h03, 24'h123456, 16'hFFFF, 1'b0);
        run_frame(8, "valid3");

        for (int k = 0; k < 14; k++) begin
            kind = $urandom_range(0, 7);
            make_frame(8'($urandom_range(0, 4)), 24'($urandom), 16'($urandom), kind == 1);
            if (kind == 2) begin
                fr[0] = 8'($urandom_range(0, 255));
                if (fr[0] == 8'hA5) fr[0] = 8'h00;
            end
            n = (kind == 3) ? $urandom_range(0, 7) : 8;
            run_frame(n, "rnd");
        end

        make_frame(8'h02, 24'h00BEEF, 16'h4242, 1'b0);
        run_frame(8, "pre_rst");

        // Reset in the middle of byte 2, then finish the frame's pin activity.
        s0 = stb_cnt;
        e0 = err_cnt;
        make_frame(8'h03, 24'h111111, 16'h2222, 1'b0);
        spi.spi_cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < 20; i++) begin
            spi.spi_mosi = fr[i / 8][7 - (i % 8)];
            tick(H);
            spi.spi_sck = 1'b1;
            tick(H);
            spi.spi_sck = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_val("midrst:pic", {56'd0, pic_dat}, 64'd1);
        check_val("midrst:fre", {40'd0, fre_dat}, 64'd0);
        check_val("midrst:amp", {48'd0, amp_dat}, 64'd0);
        check_val("midrst:ok", {63'd0, SPI_OK}, 64'd0);
        check_val("midrst:miso", {63'd0, spi.spi_miso}, 64'd0);
        tick(1);
        rst = 1'b0;
        model_reset();
        for (int i = 20; i < 64; i++) begin
            spi.spi_mosi = fr[i / 8][7 - (i % 8)];
            tick(H);
            spi.spi_sck = 1'b1;
            tick(H);
            spi.spi_sck = 1'b0;
        end
        tick(H);
        spi.spi_cs_n = 1'b1;
        tick(12);
        check_val("midrst:no_events", 64'(stb_cnt - s0 + err_cnt - e0), 64'd0);
        check_val("midrst:pic_hold", {56'd0, pic_dat}, 64'd1);

        make_frame(8'h01, 24'h0F0F0F, 16'hA5A5, 1'b0);
        run_frame(8, "post_rst");

        check_val("strobe_overlap", 64'(both_cnt), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
